// File: rtl/simd_wb_queue_pkg.sv
// Shared SIMD write-back definitions.
// Namespace bits, error-flag indices and FSM states.
package simd_wb_queue_pkg;

  localparam int NUM_NS = 6;

  localparam int NS_OBUF   = 0;
  localparam int NS_IBUF   = 1;
  localparam int NS_VMEM1  = 2;
  localparam int NS_VMEM2  = 3;
  localparam int NS_IMM    = 4;
  localparam int NS_EXTMEM = 5;

  localparam int ERR_OVF   = 0;
  localparam int ERR_MULTI = 1;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DRAIN,
    DONE
  } wb_state_t;

endpackage

// File: rtl/simd_wb_queue_if.sv
// Namespace buffer write bus.
// The write-back queue drives it as master.
interface simd_wb_queue_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_NS     = simd_wb_queue_pkg::NUM_NS
);

  logic [NUM_NS-1:0]     ns_wr_en;
  logic [ADDR_WIDTH-1:0] ns_wr_addr;
  logic [DATA_WIDTH-1:0] ns_wr_data;
  logic [NUM_NS-1:0]     ns_wr_ready;

  modport master (
    output ns_wr_en,
    output ns_wr_addr,
    output ns_wr_data,
    input  ns_wr_ready
  );

  modport slave (
    input  ns_wr_en,
    input  ns_wr_addr,
    input  ns_wr_data,
    output ns_wr_ready
  );

endinterface

// File: rtl/simd_wb_queue_fifo.sv
// Synchronous FIFO with extra-MSB pointers.
// Head entry is read combinationally from storage.
module simd_wb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign count = wr_ptr - rd_ptr;
  assign dout  = mem[rd_ptr[AW-1:0]];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/simd_wb_queue.sv
// SIMD write-back queue: buffers namespace writes,
// drains under per-namespace ready, flags completion.
module simd_wb_queue #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_NS       = simd_wb_queue_pkg::NUM_NS,
  parameter int DEPTH        = 8,
  parameter int AFULL_MARGIN = 2,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_NS-1:0]     buf_wr_req_in,
  input  logic [ADDR_WIDTH-1:0] buf_wr_addr_in,
  input  logic [DATA_WIDTH-1:0] wr_data_in,
  input  logic                  inst_done_in,
  simd_wb_queue_if.master       ns_bus,
  output logic                  stall_out,
  output logic                  wb_done,
  output logic [CNT_WIDTH-1:0]  wr_count,
  output logic [1:0]            err_flags
);

  import simd_wb_queue_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int W  = NUM_NS + ADDR_WIDTH + DATA_WIDTH;
  localparam logic [AW:0] STALL_AT =
    (AW+1)'(DEPTH - AFULL_MARGIN);

  wb_state_t             state;
  logic [W-1:0]          head;
  logic [NUM_NS-1:0]     head_req;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  full;
  logic                  empty;
  logic [AW:0]           count;
  logic [AW:0]           next_cnt;
  logic                  req_any;
  logic                  req_one;
  logic                  head_rdy;
  logic                  push;
  logic                  pop;

  assign req_any = |buf_wr_req_in;
  assign req_one = req_any &&
    ((buf_wr_req_in & (buf_wr_req_in - NUM_NS'(1))) == '0);

  assign head_req  = head[W-1 -: NUM_NS];
  assign head_addr = head[DATA_WIDTH +: ADDR_WIDTH];
  assign head_data = head[DATA_WIDTH-1:0];

  // Head-of-line blocking: only the head's namespace ready matters
  assign head_rdy = |(head_req & ns_bus.ns_wr_ready);
  assign pop      = !empty && head_rdy;
  assign push     = req_one && (!full || pop);

  assign ns_bus.ns_wr_en   = pop ? head_req : '0;
  assign ns_bus.ns_wr_addr = empty ? '0 : head_addr;
  assign ns_bus.ns_wr_data = empty ? '0 : head_data;

  assign next_cnt = count + (AW+1)'(push) - (AW+1)'(pop);
  assign wb_done  = (state == DONE);

  simd_wb_fifo #(
    .WIDTH (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   ({buf_wr_req_in, buf_wr_addr_in, wr_data_in}),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      stall_out <= 1'b0;
      wr_count  <= '0;
      err_flags <= '0;
    end else begin
      stall_out <= (next_cnt >= STALL_AT);
      if (req_one && full && !pop) err_flags[ERR_OVF] <= 1'b1;
      if (req_any && !req_one) err_flags[ERR_MULTI] <= 1'b1;

      if (state == IDLE && push) begin
        wr_count <= CNT_WIDTH'(pop);
      end else if (pop && wr_count != '1) begin
        wr_count <= wr_count + CNT_WIDTH'(1);
      end

      unique case (state)
        IDLE: begin
          if (push && inst_done_in) state <= DRAIN;
          else if (push)            state <= ACTIVE;
          else if (inst_done_in)    state <= DONE;
        end
        ACTIVE: if (inst_done_in) state <= DRAIN;
        DRAIN:  if (empty && !push) state <= DONE;
        DONE:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simd_wb_queue.sv
// Scoreboard bench for simd_wb_queue.
// Expected writes are queued at drive time, checked on retire.
module tb_simd_wb_queue;

  import simd_wb_queue_pkg::*;

  localparam int AWD = 32;
  localparam int DWD = 32;
  localparam int NNS = 6;
  localparam int EW  = NNS + AWD + DWD;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NNS-1:0]  req = '0;
  logic [AWD-1:0]  addr = '0;
  logic [DWD-1:0]  data = '0;
  logic            inst_done = 1'b0;
  logic            stall_out;
  logic            wb_done;
  logic [15:0]     wr_count;
  logic [1:0]      err_flags;

  logic [EW-1:0]   sb[$];
  int              n_checks = 0;
  int              n_fail = 0;
  int              done_seen = 0;

  simd_wb_queue_if #(
    .ADDR_WIDTH (AWD),
    .DATA_WIDTH (DWD),
    .NUM_NS     (NNS)
  ) ns_bus ();

  simd_wb_queue dut (
    .clk            (clk),
    .reset          (reset),
    .buf_wr_req_in  (req),
    .buf_wr_addr_in (addr),
    .wr_data_in     (data),
    .inst_done_in   (inst_done),
    .ns_bus         (ns_bus),
    .stall_out      (stall_out),
    .wb_done        (wb_done),
    .wr_count       (wr_count),
    .err_flags      (err_flags)
  );

  always #5 clk = ~clk;

  // Advance one cycle; retire-side scoreboard check at negedge
  task automatic step();
    logic [EW-1:0] exp;
    logic [EW-1:0] got;
    @(negedge clk);
    if (ns_bus.ns_wr_en !== '0) begin
      n_checks++;
      got = {ns_bus.ns_wr_en, ns_bus.ns_wr_addr, ns_bus.ns_wr_data};
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write got %h required none", got);
      end else begin
        exp = sb.pop_front();
        if (got !== exp) begin
          n_fail++;
          $display("FAIL wb_write got %h required %h", got, exp);
        end
      end
    end
    if (wb_done === 1'b1) done_seen++;
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [NNS-1:0] r,
                          input logic [AWD-1:0] a,
                          input logic [DWD-1:0] d,
                          input bit expect_accept);
    req  = r;
    addr = a;
    data = d;
    if (expect_accept) sb.push_back({r, a, d});
  endtask

  task automatic drain(input int budget);
    for (int c = 0; c < budget; c++) begin
      if (sb.size() == 0 && done_seen > 0) break;
      step();
    end
    n_checks++;
    if (sb.size() != 0 || done_seen != 1) begin
      n_fail++;
      $display("FAIL drain_timeout left=%0d done=%0d required 0/1",
               sb.size(), done_seen);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ns_bus.ns_wr_ready = '1;
    step();
    step();
    reset = 1'b0;
    n_checks += 7;
    if (ns_bus.ns_wr_en !== '0) begin
      n_fail++; $display("FAIL rst_en got %b required 0", ns_bus.ns_wr_en);
    end
    if (ns_bus.ns_wr_addr !== '0) begin
      n_fail++; $display("FAIL rst_addr got %h required 0", ns_bus.ns_wr_addr);
    end
    if (ns_bus.ns_wr_data !== '0) begin
      n_fail++; $display("FAIL rst_data got %h required 0", ns_bus.ns_wr_data);
    end
    if (stall_out !== 1'b0) begin
      n_fail++; $display("FAIL rst_stall got %b required 0", stall_out);
    end
    if (wb_done !== 1'b0) begin
      n_fail++; $display("FAIL rst_done got %b required 0", wb_done);
    end
    if (wr_count !== 16'd0) begin
      n_fail++; $display("FAIL rst_count got %0d required 0", wr_count);
    end
    if (err_flags !== 2'b00) begin
      n_fail++; $display("FAIL rst_err got %b required 00", err_flags);
    end
  endtask

  task automatic test_zero_write();
    done_seen = 0;
    inst_done = 1'b1;
    step();
    inst_done = 1'b0;
    n_checks += 2;
    if (wb_done !== 1'b1) begin
      n_fail++; $display("FAIL zw_done got %b required 1", wb_done);
    end
    if (wr_count !== 16'd0) begin
      n_fail++; $display("FAIL zw_count got %0d required 0", wr_count);
    end
    step();
    n_checks += 2;
    if (wb_done !== 1'b0) begin
      n_fail++; $display("FAIL zw_pulse got %b required 0", wb_done);
    end
    if (done_seen != 1) begin
      n_fail++; $display("FAIL zw_pulses got %0d required 1", done_seen);
    end
  endtask

  task automatic test_single();
    done_seen = 0;
    ns_bus.ns_wr_ready = '1;
    push_exp(6'b000100, 32'h10, 32'hAB, 1'b1);
    step();
    req = '0;
    inst_done = 1'b1;
    n_checks++;
    if (ns_bus.ns_wr_en !== 6'b000100) begin
      n_fail++; $display("FAIL single_latency got %b required 000100",
                         ns_bus.ns_wr_en);
    end
    step();
    inst_done = 1'b0;
    n_checks++;
    if (wb_done !== 1'b0) begin
      n_fail++; $display("FAIL single_early_done got %b required 0", wb_done);
    end
    step();
    n_checks += 3;
    if (wb_done !== 1'b1) begin
      n_fail++; $display("FAIL single_done got %b required 1", wb_done);
    end
    if (wr_count !== 16'd1) begin
      n_fail++; $display("FAIL single_count got %0d required 1", wr_count);
    end
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL single_retire got %0d left required 0",
                         sb.size());
    end
    step();
  endtask

  task automatic test_backpressure();
    done_seen = 0;
    ns_bus.ns_wr_ready = 6'b111110;
    for (int i = 0; i < 8; i++) begin
      push_exp(6'b000001, 32'h100 + i, $urandom, 1'b1);
      inst_done = (i == 7);
      step();
      if (i == 4) begin
        n_checks++;
        if (stall_out !== 1'b0) begin
          n_fail++; $display("FAIL bp_stall5 got %b required 0", stall_out);
        end
      end
      if (i == 5) begin
        n_checks++;
        if (stall_out !== 1'b1) begin
          n_fail++; $display("FAIL bp_stall6 got %b required 1", stall_out);
        end
      end
    end
    req = '0;
    inst_done = 1'b0;
    ns_bus.ns_wr_ready = '1;
    drain(40);
    n_checks += 3;
    if (wr_count !== 16'd8) begin
      n_fail++; $display("FAIL bp_count got %0d required 8", wr_count);
    end
    if (err_flags !== 2'b00) begin
      n_fail++; $display("FAIL bp_err got %b required 00", err_flags);
    end
    if (stall_out !== 1'b0) begin
      n_fail++; $display("FAIL bp_unstall got %b required 0", stall_out);
    end
  endtask

  task automatic test_overflow();
    done_seen = 0;
    ns_bus.ns_wr_ready = 6'b111110;
    for (int i = 0; i < 9; i++) begin
      push_exp(6'b000001, 32'h200 + i, 32'hC000 + i, i < 8);
      step();
      if (i == 7) begin
        n_checks++;
        if (err_flags !== 2'b00) begin
          n_fail++; $display("FAIL ovf_early got %b required 00", err_flags);
        end
      end
    end
    req = '0;
    n_checks++;
    if (err_flags !== 2'b01) begin
      n_fail++; $display("FAIL ovf_err got %b required 01", err_flags);
    end
    inst_done = 1'b1;
    step();
    inst_done = 1'b0;
    ns_bus.ns_wr_ready = '1;
    drain(40);
    n_checks++;
    if (wr_count !== 16'd8) begin
      n_fail++; $display("FAIL ovf_count got %0d required 8", wr_count);
    end
  endtask

  task automatic test_multihot();
    done_seen = 0;
    ns_bus.ns_wr_ready = '1;
    push_exp(6'b000011, 32'h300, 32'hDEAD, 1'b0);
    step();
    req = '0;
    n_checks += 2;
    if (ns_bus.ns_wr_en !== '0) begin
      n_fail++; $display("FAIL mh_write got %b required 0", ns_bus.ns_wr_en);
    end
    if (err_flags !== 2'b11) begin
      n_fail++; $display("FAIL mh_err got %b required 11", err_flags);
    end
    push_exp(6'b1 << NS_IMM, 32'h304, 32'hBEEF, 1'b1);
    inst_done = 1'b1;
    step();
    req = '0;
    inst_done = 1'b0;
    drain(10);
    n_checks++;
    if (wr_count !== 16'd1) begin
      n_fail++; $display("FAIL mh_count got %0d required 1", wr_count);
    end
  endtask

  task automatic test_back_to_back();
    int pushed = 0;
    logic [NNS-1:0] r;
    done_seen = 0;
    for (int c = 0; c < 200 && pushed < 12; c++) begin
      ns_bus.ns_wr_ready = NNS'($urandom);
      if (stall_out === 1'b0) begin
        r = NNS'(1) << $urandom_range(NNS - 1, 0);
        push_exp(r, $urandom, $urandom, 1'b1);
        pushed++;
        inst_done = (pushed == 12);
      end else begin
        req = '0;
        inst_done = 1'b0;
      end
      step();
    end
    req = '0;
    inst_done = 1'b0;
    ns_bus.ns_wr_ready = '1;
    drain(40);
    n_checks += 2;
    if (wr_count !== 16'd12) begin
      n_fail++; $display("FAIL b2b_count got %0d required 12", wr_count);
    end
    if (err_flags !== 2'b11) begin
      n_fail++; $display("FAIL b2b_err got %b required 11", err_flags);
    end
  endtask

  task automatic test_reset_mid_drain();
    ns_bus.ns_wr_ready = 6'b111110;
    for (int i = 0; i < 4; i++) begin
      push_exp(6'b000001, 32'h400 + i, 32'hF0 + i, 1'b0);
      inst_done = (i == 3);
      step();
    end
    req = '0;
    inst_done = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    ns_bus.ns_wr_ready = '1;
    n_checks += 4;
    if (ns_bus.ns_wr_en !== '0) begin
      n_fail++; $display("FAIL rmd_en got %b required 0", ns_bus.ns_wr_en);
    end
    if (ns_bus.ns_wr_data !== '0) begin
      n_fail++; $display("FAIL rmd_data got %h required 0", ns_bus.ns_wr_data);
    end
    if (wr_count !== 16'd0) begin
      n_fail++; $display("FAIL rmd_count got %0d required 0", wr_count);
    end
    if (err_flags !== 2'b00) begin
      n_fail++; $display("FAIL rmd_err got %b required 00", err_flags);
    end
    done_seen = 0;
    for (int c = 0; c < 6; c++) step();
    n_checks++;
    if (done_seen != 0) begin
      n_fail++; $display("FAIL rmd_done got %0d required 0", done_seen);
    end
  endtask

  initial begin
    ns_bus.ns_wr_ready = '1;
    test_reset();
    test_zero_write();
    test_single();
    test_backpressure();
    test_overflow();
    test_multihot();
    test_back_to_back();
    test_reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
